// File: rtl/cpu_loader_pkg.sv
// Shared encodings for the cpu image loader: write targets, RUN command, FSM states.
package cpu_loader_pkg;

    localparam logic [1:0] TGT_IMEM = 2'd0;
    localparam logic [1:0] TGT_DMEM = 2'd1;
    localparam logic [1:0] TGT_RF   = 2'd2;

    localparam logic [7:0] CMD_RUN  = 8'hFF;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        AH   = 3'd1,
        AL   = 3'd2,
        CH   = 3'd3,
        CL   = 3'd4,
        DATA = 3'd5,
        RUN  = 3'd6,
        ERR  = 3'd7
    } state_t;

    // States in which the loader takes bytes from the host link
    function automatic logic accepts_bytes(input state_t s);
        return (s != RUN) && (s != ERR);
    endfunction

endpackage

// File: rtl/cpu_image_loader_if.sv
// Host byte stream in, cpu memory write bus out.
interface cpu_image_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [1:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Environment side: drives the byte link, observes memory writes
    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );

    // Loader side
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );
endinterface

// File: rtl/loader_word_asm.sv
// Assembles four accepted bytes (MSB first) into a 32-bit word.
// word_ready is combinational and coincides with the 4th byte's handshake,
// so the owner can register the write on that same edge.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);
    logic [1:0]  idx;
    logic [23:0] shreg;

    assign word       = {shreg, byte_in};
    assign word_ready = byte_vld && (idx == 2'd3);

    // Byte index and the three leading bytes of the word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            shreg <= 24'd0;
        end else if (clr) begin
            idx   <= 2'd0;
        end else if (byte_vld) begin
            shreg <= {shreg[15:0], byte_in};
            idx   <= idx + 2'd1;
        end
    end
endmodule

// File: rtl/cpu_image_loader.sv
// Frame parser that loads IMEM/DMEM/RF from a host byte stream and holds the
// cpu stalled until a RUN command. Frame: TGT, addr(16b BE), cnt(16b BE), cnt words.
module cpu_image_loader
    import cpu_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int RF_DEPTH   = 32,
    parameter int ADDR_W     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_image_loader_if.slave   bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);
    state_t      state, state_nxt;
    logic [1:0]  tgt;
    logic [15:0] addr;
    logic [15:0] cnt;
    logic        acc;
    logic [15:0] cnt_full;
    logic [16:0] span;
    logic [16:0] depth;
    logic [31:0] word;
    logic        word_ready;

    assign acc      = bus.in_valid && bus.in_ready;
    // Full count is only meaningful while the cnt_lo byte is on the link
    assign cnt_full = {cnt[15:8], bus.in_data};
    // 17-bit sum so addr near 0xFFFF cannot wrap into an apparently legal range
    assign span     = {1'b0, addr} + {1'b0, cnt_full};

    loader_word_asm u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state != DATA),
        .byte_vld   (acc && (state == DATA)),
        .byte_in    (bus.in_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // Depth of the currently latched target
    always_comb begin
        depth = 17'(RF_DEPTH);
        case (tgt)
            TGT_IMEM: depth = 17'(IMEM_DEPTH);
            TGT_DMEM: depth = 17'(DMEM_DEPTH);
            default:  depth = 17'(RF_DEPTH);
        endcase
    end

    // Frame FSM next state; RUN and ERR never see a handshake
    always_comb begin
        state_nxt = state;
        if (acc) begin
            case (state)
                HDR: begin
                    if (bus.in_data <= 8'h02)        state_nxt = AH;
                    else if (bus.in_data == CMD_RUN) state_nxt = RUN;
                    else                             state_nxt = ERR;
                end
                AH:  state_nxt = AL;
                AL:  state_nxt = CH;
                CH:  state_nxt = CL;
                CL: begin
                    if (span > depth)          state_nxt = ERR;
                    else if (cnt_full == 16'd0) state_nxt = HDR;
                    else                        state_nxt = DATA;
                end
                DATA: begin
                    if (word_ready && cnt == 16'd1) state_nxt = HDR;
                end
                default: ;
            endcase
        end
    end

    // State, header fields and the running address/count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
            tgt   <= TGT_IMEM;
            addr  <= 16'd0;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                case (state)
                    HDR:  if (bus.in_data <= 8'h02) tgt <= bus.in_data[1:0];
                    AH:   addr[15:8] <= bus.in_data;
                    AL:   addr[7:0]  <= bus.in_data;
                    CH:   cnt[15:8]  <= bus.in_data;
                    CL:   cnt[7:0]   <= bus.in_data;
                    DATA: if (word_ready) begin
                        addr <= addr + 16'd1;
                        cnt  <= cnt - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs; status follows the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_sel   <= 2'd0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            bus.in_ready <= accepts_bytes(state_nxt);
            cpu_hold     <= (state_nxt != RUN);
            done         <= (state_nxt == RUN);
            error        <= (state_nxt == ERR);
            bus.mem_we   <= 1'b0;
            if (acc && state == DATA && word_ready) begin
                bus.mem_we    <= 1'b1;
                bus.mem_sel   <= tgt;
                bus.mem_addr  <= addr[ADDR_W-1:0];
                bus.mem_wdata <= word;
            end
        end
    end
endmodule

// File: tb/tb_cpu_image_loader.sv
// Randomized bench: frames are built from (target, addr, words) and expanded
// into a per-byte expectation of the write strobe and status after each handshake.
module tb_cpu_image_loader;
    localparam int ST_OK  = 0;
    localparam int ST_ERR = 1;
    localparam int ST_RUN = 2;

    typedef struct {
        logic [7:0]  b;
        int          st;
        logic        we;
        logic [1:0]  sel;
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_hold, done, error;

    int n_vec = 0;
    int n_err = 0;
    exp_t q[$];
    logic [31:0] wq[$];

    cpu_image_loader_if #(.ADDR_W(10)) bus ();

    cpu_image_loader #(
        .IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .RF_DEPTH(32), .ADDR_W(10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input int st, input logic we,
                        input logic [1:0] sel, input logic [9:0] a, input logic [31:0] d);
        exp_t e;
        e.b = b; e.st = st; e.we = we; e.sel = sel; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    // Expand one frame into bytes + expectations; words come from wq
    task automatic add_frame(input int tgt, input int addr, input int cnt);
        int depth;
        logic [31:0] w;
        if (tgt > 2) begin
            push(8'(tgt), ST_ERR, 1'b0, 2'd0, 10'd0, 32'd0);
            return;
        end
        depth = (tgt == 2) ? 32 : 1024;
        push(8'(tgt), ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
        push(8'(addr >> 8), ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
        push(8'(addr), ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
        push(8'(cnt >> 8), ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
        if (addr + cnt > depth) begin
            push(8'(cnt), ST_ERR, 1'b0, 2'd0, 10'd0, 32'd0);
            return;
        end
        push(8'(cnt), ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
        for (int k = 0; k < cnt; k++) begin
            w = wq[k];
            push(w[31:24], ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
            push(w[23:16], ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
            push(w[15:8],  ST_OK, 1'b0, 2'd0, 10'd0, 32'd0);
            push(w[7:0],   ST_OK, 1'b1, 2'(tgt), 10'(addr + k), w);
        end
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back($urandom);
    endtask

    // mode 0: back-to-back, 1: valid 1 of 3 cycles, 2: random gaps
    task automatic send_byte(input exp_t e, input int mode);
        bit got;
        int gap;
        logic [3:0] st_exp, st_act;
        gap = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            n_vec++;
            if (bus.mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL gap_we: mem_we=%b required 0", bus.mem_we);
            end
        end
        bus.in_data  = e.b;
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            got = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL handshake_timeout: byte %h never accepted", e.b);
        end
        n_vec++;
        if (bus.mem_we !== e.we) begin
            n_err++;
            $display("FAIL mem_we: byte %h got %b required %b", e.b, bus.mem_we, e.we);
        end else if (e.we) begin
            n_vec++;
            if ({bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== {e.sel, e.addr, e.data}) begin
                n_err++;
                $display("FAIL write: got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                         bus.mem_sel, bus.mem_addr, bus.mem_wdata, e.sel, e.addr, e.data);
            end
        end
        st_exp = {e.st == ST_OK, e.st == ST_ERR, e.st == ST_RUN, e.st != ST_RUN};
        st_act = {bus.in_ready, error, done, cpu_hold};
        n_vec++;
        if (st_act !== st_exp) begin
            n_err++;
            $display("FAIL status {rdy,err,done,hold}: byte %h got %b required %b", e.b, st_act, st_exp);
        end
    endtask

    task automatic run_stream(input int mode, input int limit);
        exp_t e;
        for (int i = 0; i < limit && q.size() > 0; i++) begin
            e = q.pop_front();
            send_byte(e, mode);
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({bus.in_ready, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error}
            !== {1'b0, 1'b0, 2'd0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b we=%b sel=%0d addr=%0d wd=%h hold=%b done=%b err=%b",
                     bus.in_ready, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error);
        end
        #3 rst_n = 1'b1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b required 0", bus.in_ready);
        end
        tick();
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
        end
        repeat (8) begin
            tick();
            n_vec++;
            if (bus.mem_we !== 1'b0 || cpu_hold !== 1'b1) begin
                n_err++;
                $display("FAIL idle: mem_we=%b hold=%b required 0/1", bus.mem_we, cpu_hold);
            end
        end
    endtask

    task automatic test_imem_frame();
        do_reset();
        wq.delete();
        wq.push_back(32'h20080005);
        wq.push_back(32'h21290001);
        add_frame(0, 16'h0010, 2);
        run_stream(0, 1000);
    endtask

    task automatic test_range();
        do_reset();
        rand_words(2);
        add_frame(2, 16'h001E, 2);          // ends exactly at RF_DEPTH: legal
        add_frame(2, 16'h001F, 2);          // one past: rejected
        run_stream(0, 1000);
        repeat (3) begin
            tick();
            n_vec++;
            if ({bus.mem_we, error, bus.in_ready, cpu_hold} !== 4'b0101) begin
                n_err++;
                $display("FAIL err_sticky {we,err,rdy,hold}: got %b required 0101",
                         {bus.mem_we, error, bus.in_ready, cpu_hold});
            end
        end
        do_reset();
        rand_words(1);
        add_frame(0, 16'hFFFF, 1);          // would wrap in 16 bits
        run_stream(2, 1000);
    endtask

    task automatic test_run();
        do_reset();
        wq.delete();
        wq.push_back(32'hAABBCCDD);
        add_frame(1, 16'h03FF, 1);
        push(8'hFF, ST_RUN, 1'b0, 2'd0, 10'd0, 32'd0);
        run_stream(0, 1000);
        bus.in_valid = 1'b1;
        repeat (6) begin
            bus.in_data = 8'($urandom);
            tick();
            n_vec++;
            if ({bus.in_ready, bus.mem_we, done, cpu_hold} !== 4'b0010) begin
                n_err++;
                $display("FAIL run_terminal {rdy,we,done,hold}: got %b required 0010",
                         {bus.in_ready, bus.mem_we, done, cpu_hold});
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_bad_hdr();
        do_reset();
        add_frame(5, 0, 0);
        run_stream(0, 1000);
    endtask

    task automatic test_mid_reset();
        do_reset();
        rand_words(1);
        add_frame(1, int'($urandom_range(0, 1023)), 1);
        run_stream(0, 7);                   // header + 2 data bytes
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.in_ready, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error}
            !== {1'b0, 1'b0, 2'd0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: rdy=%b we=%b hold=%b done=%b err=%b",
                     bus.in_ready, bus.mem_we, cpu_hold, done, error);
        end
        tick();
        n_vec++;
        if (bus.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_write: mem_we=%b required 0", bus.mem_we);
        end
        q.delete();
        rst_n = 1'b1;
        tick();
        rand_words(2);
        add_frame(1, int'($urandom_range(0, 1022)), 2);
        run_stream(0, 1000);
    endtask

    task automatic test_cnt_zero_throttle();
        int a;
        do_reset();
        wq.delete();
        add_frame(0, 0, 0);
        rand_words(3);
        a = int'($urandom_range(0, 1021));
        add_frame(0, a, 3);
        run_stream(0, 1000);
        add_frame(0, a, 3);                 // same words again, valid 1 of 3 cycles
        run_stream(1, 1000);
    endtask

    task automatic test_random();
        int t, c, a;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            t = int'($urandom_range(0, 2));
            c = int'($urandom_range(1, 4));
            a = int'($urandom_range(0, ((t == 2) ? 32 : 1024) - c));
            rand_words(c);
            add_frame(t, a, c);
            run_stream(f % 3, 1000);
        end
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_imem_frame();
        test_range();
        test_run();
        test_bad_hdr();
        test_mid_reset();
        test_cnt_zero_throttle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
